logic_result_stage: RTL

Registered result stage directly downstream of the 8-bit combinational logic unit. Each cycle it can accept one operation code together with that unit's seven result buses, select the addressed result, and buffer it in a 2-entry FIFO. The buffered result is presented to the consumer over a valid/ready handshake. The block also keeps a transaction counter and a sticky illegal-opcode flag.

---
 rtl/logic_pkg.sv | 17 +
 rtl/logic_fifo2.sv | 64 ++++++
 rtl/logic_result_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the logic result stage: opcode encodings and default data width.
package logic_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_NOT     = 3'd1,
        OP_AND     = 3'd2,
        OP_OR      = 3'd3,
        OP_XOR     = 3'd4,
        OP_XNOR    = 3'd5,
        OP_RAND    = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

endpackage

// File: rtl/logic_fifo2.sv
// Generic 2-entry FIFO with valid/ready on both sides.
// The head entry is a register, so out_data_o is glitch-free and resets to 0.
// in_ready_o depends only on the occupancy register, never on out_ready_i.
module logic_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Next-state for occupancy and the two storage slots.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop && count_q == 2'd2) begin
            head_d = tail_q;
        end
        if (push) begin
            // Empty, or draining the single entry this cycle: new data lands at the head.
            if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                head_d = in_data_i;
            end else begin
                tail_d = in_data_i;
            end
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/logic_result_stage.sv
// Result stage behind the 8-bit logic unit: selects the addressed result,
// buffers it in a 2-entry FIFO, counts accepted transactions and flags
// illegal opcodes (sticky).
// Optional build macro LOGIC_RESULT_FLAGS_EN adds registered po_zero and
// po_parity outputs describing the head-of-buffer result.
module logic_result_stage
    import logic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] pi_c,
    input  logic [DATA_W-1:0] pi_d,
    input  logic [DATA_W-1:0] pi_e,
    input  logic [DATA_W-1:0] pi_f,
    input  logic [DATA_W-1:0] pi_g,
    input  logic [DATA_W-1:0] pi_h,
    input  logic [DATA_W-1:0] pi_i,
    input  logic [2:0]        pi_op,
    input  logic              pi_valid,
    output logic              po_ready,
    output logic [DATA_W-1:0] po_data,
    output logic              po_valid,
    input  logic              pi_ready,
    input  logic              pi_err_clr,
    output logic              po_err,
`ifdef LOGIC_RESULT_FLAGS_EN
    output logic              po_zero,
    output logic              po_parity,
`endif
    output logic [CNT_W-1:0]  po_cnt
);

    logic [DATA_W-1:0] sel_data;
    logic              push, pop;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    assign push = pi_valid && po_ready;
    assign pop  = po_valid && pi_ready;

    // Result select; the illegal opcode is still accepted but stores zero.
    always_comb begin
        sel_data = '0;
        case (pi_op)
            OP_ADD:  sel_data = pi_c;
            OP_NOT:  sel_data = pi_d;
            OP_AND:  sel_data = pi_e;
            OP_OR:   sel_data = pi_f;
            OP_XOR:  sel_data = pi_g;
            OP_XNOR: sel_data = pi_h;
            OP_RAND: sel_data = pi_i;
            default: sel_data = '0;
        endcase
    end

    logic_fifo2 #(
        .W (DATA_W)
    ) u_fifo (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .in_data_i   (sel_data),
        .in_valid_i  (pi_valid),
        .in_ready_o  (po_ready),
        .out_data_o  (po_data),
        .out_valid_o (po_valid),
        .out_ready_i (pi_ready)
    );

    // Counter wraps silently; an illegal push beats a simultaneous clear.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (push) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (push && pi_op == OP_ILLEGAL) begin
            err_d = 1'b1;
        end else if (pi_err_clr) begin
            err_d = 1'b0;
        end
    end

    // Transaction counter and sticky error flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign po_cnt = cnt_q;
    assign po_err = err_q;

`ifdef LOGIC_RESULT_FLAGS_EN
    // Flags shadow the FIFO slots: head flags follow po_data, tail flags wait
    // for the second entry to move up. Occupancy is inferred from po_valid/po_ready.
    logic zero_q, zero_d, par_q, par_d;
    logic tzero_q, tzero_d, tpar_q, tpar_d;

    always_comb begin
        zero_d  = zero_q;
        par_d   = par_q;
        tzero_d = tzero_q;
        tpar_d  = tpar_q;
        if (pop && !po_ready) begin
            zero_d = tzero_q;
            par_d  = tpar_q;
        end
        if (push) begin
            if (!po_valid || pop) begin
                zero_d = (sel_data == '0);
                par_d  = ^sel_data;
            end else begin
                tzero_d = (sel_data == '0);
                tpar_d  = ^sel_data;
            end
        end
    end

    // Flag registers, updated on the same edge as the head data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            zero_q  <= 1'b0;
            par_q   <= 1'b0;
            tzero_q <= 1'b0;
            tpar_q  <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            par_q   <= par_d;
            tzero_q <= tzero_d;
            tpar_q  <= tpar_d;
        end
    end

    assign po_zero   = zero_q;
    assign po_parity = par_q;
`endif

endmodule
